// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file write-back path: source ids and select encoding.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package rf_pkg;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_ACC = 2'd1,
    SRC_MEM = 2'd2
  } src_e;

  localparam int NUM_SRC = 3;

  // Returns {from_ALU, from_Acc, from_Mem} for a source id.
  function automatic logic [2:0] src_onehot(src_e s);
    logic [2:0] oh;
    oh = 3'b000;
    case (s)
      SRC_ALU: oh = 3'b100;
      SRC_ACC: oh = 3'b010;
      SRC_MEM: oh = 3'b001;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Producer/decode/register-file bundle around the write-back arbiter.
// Latency: n/a (wiring only).
// Backpressure: producers hold *_valid until *_ready; decode holds rsv_valid until rsv_ready.
interface rf_wb_arbiter_if #(
  parameter int A = 4,
  parameter int W = 8
);
  logic         alu_valid, acc_valid, mem_valid;
  logic [A-1:0] alu_addr, acc_addr, mem_addr;
  logic [W-1:0] alu_data, acc_data, mem_data;
  logic         alu_ready, acc_ready, mem_ready;

  logic         rsv_valid;
  logic [A-1:0] rsv_addr;
  logic         rsv_ready;
  logic [A-1:0] rd_addr;
  logic         rd_busy;

  logic         Write_En;
  logic         from_ALU, from_Acc, from_Mem;
  logic [A-1:0] address;
  logic [W-1:0] ALU_Input, Acc_Input, Mem_Input;

  // Producer, decode and register-file side.
  modport master (
    output alu_valid, acc_valid, mem_valid,
    output alu_addr, acc_addr, mem_addr,
    output alu_data, acc_data, mem_data,
    input  alu_ready, acc_ready, mem_ready,
    output rsv_valid, rsv_addr, rd_addr,
    input  rsv_ready, rd_busy,
    input  Write_En, from_ALU, from_Acc, from_Mem, address,
    input  ALU_Input, Acc_Input, Mem_Input
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, acc_valid, mem_valid,
    input  alu_addr, acc_addr, mem_addr,
    input  alu_data, acc_data, mem_data,
    output alu_ready, acc_ready, mem_ready,
    input  rsv_valid, rsv_addr, rd_addr,
    output rsv_ready, rd_busy,
    output Write_En, from_ALU, from_Acc, from_Mem, address,
    output ALU_Input, Acc_Input, Mem_Input
  );
endinterface

// File: rtl/rf_wb_arbiter_rr_arbiter3.sv
// Three-way round-robin arbiter; search starts just after the last accepted source.
// Latency: grant is combinational from requests and pointer; pointer moves on accept.
// Backpressure: pointer holds when i_accept is low, so an unaccepted grant is re-offered.
module rr_arbiter3 import rf_pkg::*; #(
  parameter src_e RST_PTR = SRC_MEM
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [NUM_SRC-1:0] i_req,
  input  logic               i_accept,
  output logic [NUM_SRC-1:0] o_gnt,
  output src_e               o_gnt_src
);

  src_e r_ptr;
  src_e w_ord [NUM_SRC];

  // Search order: the three sources starting one after the last winner.
  always_comb begin
    w_ord[0] = SRC_ALU;
    w_ord[1] = SRC_ACC;
    w_ord[2] = SRC_MEM;
    case (r_ptr)
      SRC_ALU: begin w_ord[0] = SRC_ACC; w_ord[1] = SRC_MEM; w_ord[2] = SRC_ALU; end
      SRC_ACC: begin w_ord[0] = SRC_MEM; w_ord[1] = SRC_ALU; w_ord[2] = SRC_ACC; end
      default: ;
    endcase
  end

  // First requester in search order wins; no requester means no grant.
  always_comb begin
    o_gnt     = '0;
    o_gnt_src = r_ptr;
    if (i_req[w_ord[0]]) begin
      o_gnt[w_ord[0]] = 1'b1;
      o_gnt_src       = w_ord[0];
    end else if (i_req[w_ord[1]]) begin
      o_gnt[w_ord[1]] = 1'b1;
      o_gnt_src       = w_ord[1];
    end else if (i_req[w_ord[2]]) begin
      o_gnt[w_ord[2]] = 1'b1;
      o_gnt_src       = w_ord[2];
    end
  end

  // Last-grant pointer advances only when the grant is actually taken.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_ptr <= RST_PTR;
    end else if (i_accept) begin
      r_ptr <= o_gnt_src;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the single-port register file plus per-register pending-write scoreboard.
// Latency: transfer at edge E0 drives Write_En in cycle E0->E1; count drops at E1.
// Backpressure: one producer is granted per cycle round-robin; reservations stall when a count is saturated.
module rf_wb_arbiter import rf_pkg::*; #(
  parameter int A  = 4,
  parameter int W  = 8,
  parameter int CW = 2
) (
  input  logic            clk,
  input  logic            Reset,
  rf_wb_arbiter_if.slave  bus
);

  localparam int            NREG    = 1 << A;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_gnt;
  src_e               w_gnt_src;
  logic               w_xfer;
  logic [A-1:0]       w_sel_addr;
  logic [W-1:0]       w_sel_data;

  logic               r_we;
  logic [2:0]         r_from;
  logic [A-1:0]       r_addr;
  logic [W-1:0]       r_alu_lane, r_acc_lane, r_mem_lane;

  logic [CW-1:0]      r_cnt [NREG];
  logic               w_rsv_rdy;
  logic               w_rsv_acc;
  logic [NREG-1:0]    w_inc, w_dec;

  // Request vector indexed by src_e.
  assign w_req  = {bus.mem_valid, bus.acc_valid, bus.alu_valid};
  assign w_xfer = (|w_gnt) & ~Reset;

  rr_arbiter3 #(.RST_PTR(SRC_MEM)) u_arb (
    .clk       (clk),
    .Reset     (Reset),
    .i_req     (w_req),
    .i_accept  (w_xfer),
    .o_gnt     (w_gnt),
    .o_gnt_src (w_gnt_src)
  );

  assign bus.alu_ready = w_gnt[SRC_ALU] & ~Reset;
  assign bus.acc_ready = w_gnt[SRC_ACC] & ~Reset;
  assign bus.mem_ready = w_gnt[SRC_MEM] & ~Reset;

  // Address/data of the granted source.
  always_comb begin
    w_sel_addr = bus.mem_addr;
    w_sel_data = bus.mem_data;
    case (w_gnt_src)
      SRC_ALU: begin w_sel_addr = bus.alu_addr; w_sel_data = bus.alu_data; end
      SRC_ACC: begin w_sel_addr = bus.acc_addr; w_sel_data = bus.acc_data; end
      default: ;
    endcase
  end

  // Register-file port stage: strobe and select follow transfers; address and lanes hold when idle.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_we       <= 1'b0;
      r_from     <= 3'b000;
      r_addr     <= '0;
      r_alu_lane <= '0;
      r_acc_lane <= '0;
      r_mem_lane <= '0;
    end else if (w_xfer) begin
      r_we       <= 1'b1;
      r_from     <= src_onehot(w_gnt_src);
      r_addr     <= w_sel_addr;
      r_alu_lane <= (w_gnt_src == SRC_ALU) ? w_sel_data : '0;
      r_acc_lane <= (w_gnt_src == SRC_ACC) ? w_sel_data : '0;
      r_mem_lane <= (w_gnt_src == SRC_MEM) ? w_sel_data : '0;
    end else begin
      r_we   <= 1'b0;
      r_from <= 3'b000;
    end
  end

  // Strobe is masked by Reset so an in-flight write is not captured at the reset edge.
  assign bus.Write_En  = r_we & ~Reset;
  assign bus.from_ALU  = r_from[2];
  assign bus.from_Acc  = r_from[1];
  assign bus.from_Mem  = r_from[0];
  assign bus.address   = r_addr;
  assign bus.ALU_Input = r_alu_lane;
  assign bus.Acc_Input = r_acc_lane;
  assign bus.Mem_Input = r_mem_lane;

  // Hazard status reads the registered counts only; a commit on this edge is not bypassed.
  assign w_rsv_rdy     = (r_cnt[bus.rsv_addr] != CNT_MAX);
  assign w_rsv_acc     = bus.rsv_valid & w_rsv_rdy;
  assign bus.rsv_ready = w_rsv_rdy;
  assign bus.rd_busy   = (r_cnt[bus.rd_addr] != '0);

  // Per-register increment (accepted reservation) and decrement (commit) strobes.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_rsv_acc) w_inc[bus.rsv_addr] = 1'b1;
    if (r_we)      w_dec[r_addr]       = 1'b1;
  end

  // Pending counts: simultaneous +1/-1 cancel; a commit to an idle register stays at zero.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic vs a behavioural model.
// Latency: model mirrors one-cycle write-port delay and no-bypass hazard status.
// Backpressure: producers drop or hold valid at random; reservations retried at random.
module tb_rf_wb_arbiter;

  localparam int CMAX = 3;

  logic clk;
  logic Reset;
  int   n_chk;
  int   n_err;

  rf_wb_arbiter_if #(.A(4), .W(8)) bus ();

  rf_wb_arbiter #(.A(4), .W(8), .CW(2)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file as the real consumer would see it, fed only from DUT outputs.
  logic [7:0] rf [16];
  initial for (int i = 0; i < 16; i++) rf[i] = 8'h00;
  always @(posedge clk) begin
    if (bus.Write_En) begin
      if (bus.from_ALU)      rf[bus.address] <= bus.ALU_Input;
      else if (bus.from_Acc) rf[bus.address] <= bus.Acc_Input;
      else if (bus.from_Mem) rf[bus.address] <= bus.Mem_Input;
    end
  end

  // Behavioural model state.
  bit         m_live;
  int         m_ptr;
  bit         m_we;
  int         m_src;
  logic [3:0] m_addr;
  logic [7:0] m_lane [3];
  int         m_cnt [16];
  logic [7:0] m_rf [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] addr_of(int s);
    if (s == 0) return bus.alu_addr;
    if (s == 1) return bus.acc_addr;
    return bus.mem_addr;
  endfunction

  function automatic logic [7:0] data_of(int s);
    if (s == 0) return bus.alu_data;
    if (s == 1) return bus.acc_data;
    return bus.mem_data;
  endfunction

  // Winner: first valid source after the last winner in order ALU, Acc, Mem; -1 if none.
  function automatic int exp_grant();
    bit v [3];
    v[0] = bus.alu_valid;
    v[1] = bus.acc_valid;
    v[2] = bus.mem_valid;
    if (Reset) return -1;
    for (int k = 1; k <= 3; k++) if (v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    return -1;
  endfunction

  // Compare every DUT output against the model; called mid-cycle after inputs settle.
  task automatic probe();
    int         g;
    logic [2:0] er;
    logic [2:0] ef;
    #1;
    if (!m_live) return;
    g  = exp_grant();
    er = 3'b000;
    if (g >= 0) er[2 - g] = 1'b1;
    ef = 3'b000;
    if (m_we) ef[2 - m_src] = 1'b1;
    chk("ready", {bus.alu_ready, bus.acc_ready, bus.mem_ready}, er);
    chk("rsv_ready", bus.rsv_ready, m_cnt[bus.rsv_addr] != CMAX);
    chk("rd_busy", bus.rd_busy, m_cnt[bus.rd_addr] != 0);
    chk("write_en", bus.Write_En, m_we && !Reset);
    chk("from", {bus.from_ALU, bus.from_Acc, bus.from_Mem}, ef);
    chk("address", bus.address, m_addr);
    chk("alu_lane", bus.ALU_Input, m_lane[0]);
    chk("acc_lane", bus.Acc_Input, m_lane[1]);
    chk("mem_lane", bus.Mem_Input, m_lane[2]);
  endtask

  // Advance the model by one clock edge using the inputs held over that edge.
  task automatic update();
    int g;
    bit racc;
    int ra;
    if (Reset) begin
      m_live = 1;
      m_ptr  = 2;
      m_we   = 0;
      m_src  = 0;
      m_addr = '0;
      for (int i = 0; i < 3; i++)  m_lane[i] = '0;
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      return;
    end
    if (!m_live) return;
    g    = exp_grant();
    ra   = int'(bus.rsv_addr);
    racc = bus.rsv_valid && (m_cnt[ra] != CMAX);
    if (m_we) m_rf[m_addr] = m_lane[m_src];
    if (!(racc && m_we && (ra == int'(m_addr)))) begin
      if (racc) m_cnt[ra]++;
      if (m_we && m_cnt[m_addr] > 0) m_cnt[m_addr]--;
    end
    if (g >= 0) begin
      m_we   = 1;
      m_src  = g;
      m_addr = addr_of(g);
      for (int i = 0; i < 3; i++) m_lane[i] = '0;
      m_lane[g] = data_of(g);
      m_ptr  = g;
    end else begin
      m_we = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic step();
    probe();
    tick();
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 0; bus.acc_valid = 0; bus.mem_valid = 0;
    bus.rsv_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    m_live = 0;
    m_ptr = 2; m_we = 0; m_src = 0; m_addr = '0;
    for (int i = 0; i < 3; i++)  m_lane[i] = '0;
    for (int i = 0; i < 16; i++) begin m_cnt[i] = 0; m_rf[i] = 8'h00; end
    idle_inputs();
    bus.alu_addr = '0; bus.acc_addr = '0; bus.mem_addr = '0;
    bus.alu_data = '0; bus.acc_data = '0; bus.mem_data = '0;
    bus.rsv_addr = '0; bus.rd_addr = '0;
    Reset = 1;

    @(negedge clk);
    step();
    step();
    Reset = 0;

    // Reset state.
    probe();
    chk("rst_write_en", bus.Write_En, 1'b0);
    chk("rst_rsv_ready", bus.rsv_ready, 1'b1);
    chk("rst_rd_busy", bus.rd_busy, 1'b0);
    chk("rst_address", bus.address, 4'h0);
    tick();

    // All three valid: ALU, Acc, Mem, ALU, ... on consecutive cycles.
    bus.alu_valid = 1; bus.alu_addr = 4'd1; bus.alu_data = 8'h11;
    bus.acc_valid = 1; bus.acc_addr = 4'd2; bus.acc_data = 8'h22;
    bus.mem_valid = 1; bus.mem_addr = 4'd3; bus.mem_data = 8'h33;
    for (int k = 0; k < 6; k++) begin
      probe();
      chk("rr_grant", {bus.alu_ready, bus.acc_ready, bus.mem_ready}, 3'b100 >> (k % 3));
      if (k > 0) begin
        chk("rr_write_en", bus.Write_En, 1'b1);
        chk("rr_from", {bus.from_ALU, bus.from_Acc, bus.from_Mem}, 3'b100 >> ((k - 1) % 3));
      end
      tick();
    end
    idle_inputs();
    step();
    step();
    chk("rf_r1", rf[1], 8'h11);
    chk("rf_r2", rf[2], 8'h22);
    chk("rf_r3", rf[3], 8'h33);

    // Two reservations on r5, then two Mem writes.
    bus.rsv_valid = 1; bus.rsv_addr = 4'd5;
    step();
    step();
    bus.rsv_valid = 0; bus.rd_addr = 4'd5;
    bus.mem_valid = 1; bus.mem_addr = 4'd5; bus.mem_data = 8'hA5;
    step();
    bus.mem_valid = 0;
    step();
    bus.mem_valid = 1;
    probe();
    chk("r5_busy_after_first", bus.rd_busy, 1'b1);
    tick();
    bus.mem_valid = 0;
    probe();
    chk("r5_busy_no_bypass", bus.rd_busy, 1'b1);
    tick();
    probe();
    chk("r5_busy_clear", bus.rd_busy, 1'b0);
    tick();

    // Reservation and commit to r4 on the same edge with cnt=1.
    bus.rsv_valid = 1; bus.rsv_addr = 4'd4;
    step();
    bus.rsv_valid = 0;
    bus.alu_valid = 1; bus.alu_addr = 4'd4; bus.alu_data = 8'h44;
    step();
    bus.alu_valid = 0;
    bus.rsv_valid = 1; bus.rsv_addr = 4'd4;
    step();
    bus.rsv_valid = 0; bus.rd_addr = 4'd4;
    probe();
    chk("r4_busy_same_edge", bus.rd_busy, 1'b1);
    tick();

    // Saturate r7; r6 still free; unreserved write to r0.
    bus.rsv_valid = 1; bus.rsv_addr = 4'd7;
    step(); step(); step();
    probe();
    chk("r7_rsv_full", bus.rsv_ready, 1'b0);
    tick();
    bus.rsv_valid = 0; bus.rsv_addr = 4'd6;
    probe();
    chk("r6_rsv_free", bus.rsv_ready, 1'b1);
    tick();
    bus.alu_valid = 1; bus.alu_addr = 4'd0; bus.alu_data = 8'h0F;
    step();
    bus.alu_valid = 0;
    step();
    bus.rd_addr = 4'd0;
    probe();
    chk("r0_unreserved", bus.rd_busy, 1'b0);
    tick();

    // Lone Acc request.
    bus.acc_valid = 1; bus.acc_addr = 4'd9; bus.acc_data = 8'h5C;
    probe();
    chk("acc_only_ready", {bus.alu_ready, bus.acc_ready, bus.mem_ready}, 3'b010);
    tick();
    bus.acc_valid = 0;
    probe();
    chk("acc_only_we", bus.Write_En, 1'b1);
    chk("acc_only_from", {bus.from_ALU, bus.from_Acc, bus.from_Mem}, 3'b010);
    chk("acc_only_addr", bus.address, 4'd9);
    chk("acc_only_acc", bus.Acc_Input, 8'h5C);
    chk("acc_only_alu", bus.ALU_Input, 8'h00);
    chk("acc_only_mem", bus.Mem_Input, 8'h00);
    tick();

    // Reset while a write to r2 is in flight.
    bus.alu_valid = 1; bus.alu_addr = 4'd2; bus.alu_data = 8'hFF;
    step();
    Reset = 1;
    probe();
    chk("ready_in_reset", bus.alu_ready, 1'b0);
    chk("we_in_reset", bus.Write_En, 1'b0);
    tick();
    Reset = 0; bus.alu_valid = 0;
    bus.rd_addr = 4'd7; bus.rsv_addr = 4'd7;
    probe();
    chk("mid_rst_we", bus.Write_En, 1'b0);
    chk("mid_rst_addr", bus.address, 4'h0);
    chk("mid_rst_alu", bus.ALU_Input, 8'h00);
    chk("mid_rst_r7_busy", bus.rd_busy, 1'b0);
    chk("mid_rst_r7_rsv", bus.rsv_ready, 1'b1);
    chk("mid_rst_r2_kept", rf[2], 8'h22);
    tick();
    bus.alu_valid = 1; bus.acc_valid = 1; bus.mem_valid = 1;
    probe();
    chk("ptr_after_reset", {bus.alu_ready, bus.acc_ready, bus.mem_ready}, 3'b100);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bus.alu_valid = ($urandom_range(0, 9) < 6);
      bus.acc_valid = ($urandom_range(0, 9) < 5);
      bus.mem_valid = ($urandom_range(0, 9) < 4);
      bus.alu_addr  = 4'($urandom_range(0, 15));
      bus.acc_addr  = 4'($urandom_range(0, 15));
      bus.mem_addr  = 4'($urandom_range(0, 15));
      bus.alu_data  = 8'($urandom);
      bus.acc_data  = 8'($urandom);
      bus.mem_data  = 8'($urandom);
      bus.rsv_valid = ($urandom_range(0, 9) < 4);
      bus.rsv_addr  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      bus.rd_addr   = 4'($urandom_range(0, 15));
      Reset         = ($urandom_range(0, 99) == 0);
      step();
    end
    Reset = 0;
    idle_inputs();
    step(); step(); step();
    for (int i = 0; i < 16; i++) chk("rf_final", rf[i], m_rf[i]);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the single-write-port register file. Three producers (ALU, accumulator, data memory) present writes through valid/ready handshakes. The block grants one write per cycle round-robin and drives the register file's write port from registered outputs. It also keeps a per-register pending-write count, so the decode stage can stall on read-after-write hazards.

## Interface
Parameters:
- A, 4, register address width (2**A registers)
- W, 8, register data width
- CW, 2, pending-count width per register (saturates at 2**CW-1)

Ports:
- clk  in  1  clock
- Reset  in  1  synchronous, active-high
- alu_valid / acc_valid / mem_valid  in  1  source has a write pending
- alu_addr / acc_addr / mem_addr  in  A  destination register
- alu_data / acc_data / mem_data  in  W  write value
- alu_ready / acc_ready / mem_ready  out  1  grant; transfer occurs when valid && ready at posedge
- rsv_valid  in  1  decode reserves a destination register
- rsv_addr  in  A  register being reserved
- rsv_ready  out  1  reservation accepted (count for rsv_addr below max)
- rd_addr  in  A  decode read-operand query
- rd_busy  out  1  rd_addr has a nonzero pending count
- Write_En  out  1  register file write strobe (registered)
- from_ALU / from_Acc / from_Mem  out  1  one-hot source select (registered)
- address  out  A  register file address (registered)
- ALU_Input / Acc_Input / Mem_Input  out  W  data lanes (registered)

## Operation
- Arbitration:
  - Round-robin over the order ALU→Acc→Mem, based on a last-grant pointer.
  - At most one *_ready is high per cycle.
  - ready is combinational from the valids and the pointer. It is high only for the granted requester that is also valid.
  - The pointer advances to the granted source only on a transfer.
  - A requester that holds valid is granted within 3 cycles.
- Write port:
  - On a transfer, the next cycle drives Write_En=1, exactly one from_* set, address = source addr, and the selected data lane = source data. The other lanes are 0.
  - With no transfer, the next cycle drives Write_En=0, all from_*=0, and holds address and data at their last values.
- Scoreboard: cnt[r] (CW bits) per register.
  - A reservation is an accepted reservation (rsv_valid && rsv_ready) → +1 for rsv_addr.
  - A commit is Write_En high at a posedge → −1 for address.
  - A reservation and a commit to the same register at the same edge leave cnt unchanged.
  - A commit to a register with cnt==0 leaves cnt at 0 (unreserved write, no underflow).
  - rsv_ready = (cnt[rsv_addr] != max).
  - rd_busy = (cnt[rd_addr] != 0).
  - Neither rsv_ready nor rd_busy has any bypass from the same-cycle commit.
- Producers are not checked against reservations. Ordering of writes to the same register is the issuer's responsibility.

## Timing
- Reset values:
  - Write_En=0; from_*=0; address=0; all data lanes 0.
  - All cnt=0, so rd_busy=0 and rsv_ready=1.
  - Pointer = Mem, so ALU has first priority.
  - All *_ready=0 while Reset is high.
- Latency:
  - A transfer at edge E0 gives Write_En high in cycle E0→E1.
  - The register file captures the value at E1.
  - cnt is decremented at E1.
  - rd_busy clears in the cycle after E1, which is when the register file read returns the new value.
- A producer may drop valid without a transfer. No state changes.
- Back-to-back transfers may occur on every cycle, giving one write per cycle sustained.
- Reset mid-operation: an in-flight Write_En is dropped (the write does not occur), counts clear, and the pointer resets. This all takes effect at the first Reset edge.

## Structure
- Shared package rf_pkg:
  - typedef src_e {SRC_ALU=0, SRC_ACC=1, SRC_MEM=2}.
  - NUM_SRC=3.
  - Helper function src_onehot(src_e) returning {from_ALU, from_Acc, from_Mem}.
- Sub-module rr_arbiter3: 3-request round-robin with grant one-hot, an advance-on-accept input, and a reset pointer parameter.
- Scoreboard counter array and the output register stage stay in the top module.

## Test plan
- After reset, ALU, Acc and Mem all valid continuously with addrs 1/2/3 and data 0x11/0x22/0x33 → grants ALU, Acc, Mem, ALU… on consecutive cycles. Write_En stays high. Lanes and from_* match each grant. Register file r1=0x11, r2=0x22, r3=0x33.
- rsv r5 twice (cnt=2), then a Mem write to r5=0xA5 → rd_busy(r5) stays 1 after the first commit. A second write clears it one cycle after the commit edge.
- A reservation and a commit to r4 at the same edge with cnt=1 → cnt stays 1 and rd_busy=1.
- Reserve r7 to cnt=3 → rsv_ready=0 for r7 and rsv_ready=1 for r6. An unreserved write to r0 leaves cnt[r0]=0.
- Only Acc valid (addr 9, 0x5C) → acc_ready the same cycle. Next cycle Write_En=1, from_Acc=1, Acc_Input=0x5C, ALU_Input=Mem_Input=0.
- Assert Reset in the cycle Write_En=1 for r2=0xFF → r2 not written, all outputs return to reset values, and all cnt=0.
